// File: rtl/rand_extractor_pkg.sv
// Shared constants and types for the rand_extractor conditioning stage.
//   SYM_ZERO / SYM_ONE : raw symbols that survive the Von Neumann debias
//   ext_state_t        : extractor FSM states
//   *_DEF              : default parameter values
package rand_pkg;

  localparam int unsigned WORD_W_DEF     = 8;
  localparam int unsigned FIFO_DEPTH_DEF = 4;
  localparam int unsigned REP_LIMIT_DEF  = 16;

  localparam logic [1:0] SYM_ZERO = 2'b01;
  localparam logic [1:0] SYM_ONE  = 2'b10;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FAULT = 1'b1
  } ext_state_t;

endpackage

// File: rtl/rand_extractor_if.sv
// Output-side bus of rand_extractor: word stream with valid/ready plus status.
//   o_data  : FIFO head word          o_valid : head word available
//   i_ready : consumer accepts head    o_count : FIFO occupancy
//   o_drop  : completed word discarded o_fault : sticky health-test failure
interface rand_extractor_if
  import rand_pkg::*;
#(
  parameter int unsigned WORD_W     = WORD_W_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) ();

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [WORD_W-1:0] o_data;
  logic              o_valid;
  logic              i_ready;
  logic [CNT_W-1:0]  o_count;
  logic              o_drop;
  logic              o_fault;

  modport master (
    output o_data, o_valid, o_count, o_drop, o_fault,
    input  i_ready
  );

  modport slave (
    input  o_data, o_valid, o_count, o_drop, o_fault,
    output i_ready
  );

endinterface

// File: rtl/rand_extractor_fifo.sv
// Synchronous first-word-fall-through FIFO holding packed words.
//   i_push/i_data : write (ignored when full unless popping the same cycle)
//   i_pop         : remove head (ignored when empty)
//   i_flush       : drop all contents; overrides push and pop
//   o_data        : head word, o_count/o_full/o_empty : occupancy status
module rand_fifo
  import rand_pkg::*;
#(
  parameter int unsigned WORD_W     = WORD_W_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                               i_clk,
  input  logic                               i_reset,
  input  logic                               i_push,
  input  logic [WORD_W-1:0]                  i_data,
  input  logic                               i_pop,
  input  logic                               i_flush,
  output logic [WORD_W-1:0]                  o_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_count,
  output logic                               o_full,
  output logic                               o_empty
);

  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
  logic [WORD_W-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic do_pop_c;
  logic do_push_c;

  assign o_full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign o_empty   = (count_q == '0);
  assign o_data    = mem_q[rd_ptr_q];
  assign o_count   = count_q;
  assign do_pop_c  = i_pop && !o_empty;
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign do_push_c = i_push && (!o_full || do_pop_c);

  // Next-state: pointer/occupancy update, flush has priority.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push_c) begin
        mem_d[wr_ptr_q] = i_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop_c) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (do_push_c && !do_pop_c) begin
        count_d = count_q + CNT_W'(1);
      end else if (do_pop_c && !do_push_c) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/rand_extractor.sv
// Conditioning stage for the randomizer core: Von Neumann debias of each raw
// 2-bit symbol, MSB-first word packing, word FIFO with valid/ready output and
// a repetition-count health test that latches a sticky fault.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_en, i_r      : sample strobe and raw symbol
//   out_if         : word stream (data/valid/ready), occupancy, drop, fault
module rand_extractor
  import rand_pkg::*;
#(
  parameter int unsigned WORD_W     = WORD_W_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned REP_LIMIT  = REP_LIMIT_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_en,
  input  logic [1:0]           i_r,
  rand_extractor_if.master     out_if
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BC_W  = $clog2(WORD_W);
  localparam int unsigned REP_W = $clog2(REP_LIMIT + 1);

  ext_state_t        state_q, state_d;
  logic [WORD_W-2:0] shreg_q, shreg_d;
  logic [BC_W-1:0]   bitcnt_q, bitcnt_d;
  logic [1:0]        prev_q, prev_d;
  logic              prev_vld_q, prev_vld_d;
  logic [REP_W-1:0]  rep_q, rep_d;
  logic              drop_q, drop_d;

  logic              sample_c;
  logic [REP_W-1:0]  rep_inc_c;
  logic              trip_c;
  logic              prod_c;
  logic              bit_c;
  logic              word_done_c;
  logic [WORD_W-1:0] word_c;
  logic              valid_c;
  logic              pop_c;
  logic              push_c;
  logic [WORD_W-1:0] fifo_data;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;

  assign sample_c    = i_en && (state_q == RUN);
  assign rep_inc_c   = (prev_vld_q && (i_r == prev_q)) ? (rep_q + REP_W'(1)) : REP_W'(1);
  assign trip_c      = sample_c && (rep_inc_c == REP_W'(REP_LIMIT));
  // The tripping sample is consumed by the health test only.
  assign prod_c      = sample_c && !trip_c && ((i_r == SYM_ZERO) || (i_r == SYM_ONE));
  assign bit_c       = (i_r == SYM_ONE);
  assign word_c      = {shreg_q, bit_c};
  assign word_done_c = prod_c && (bitcnt_q == BC_W'(WORD_W - 1));
  assign valid_c     = !fifo_empty && (state_q == RUN);
  assign pop_c       = valid_c && out_if.i_ready;
  assign push_c      = word_done_c && (!fifo_full || pop_c);

  rand_fifo #(
    .WORD_W     (WORD_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (push_c),
    .i_data  (word_c),
    .i_pop   (pop_c),
    .i_flush (trip_c),
    .o_data  (fifo_data),
    .o_count (fifo_count),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  assign out_if.o_data  = fifo_data;
  assign out_if.o_valid = valid_c;
  assign out_if.o_count = fifo_count;
  assign out_if.o_drop  = drop_q;
  assign out_if.o_fault = (state_q == FAULT);

  // Next-state: health test, FSM and packer.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bitcnt_d   = bitcnt_q;
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    rep_d      = rep_q;
    drop_d     = 1'b0;

    if (sample_c) begin
      prev_d     = i_r;
      prev_vld_d = 1'b1;
      rep_d      = rep_inc_c;
    end

    if (trip_c) begin
      state_d  = FAULT;
      shreg_d  = '0;
      bitcnt_d = '0;
    end else if (prod_c) begin
      shreg_d  = word_c[WORD_W-2:0];
      bitcnt_d = word_done_c ? '0 : (bitcnt_q + BC_W'(1));
      drop_d   = word_done_c && fifo_full && !pop_c;
    end
  end

  // State registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= RUN;
      shreg_q    <= '0;
      bitcnt_q   <= '0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      rep_q      <= '0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bitcnt_q   <= bitcnt_d;
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      rep_q      <= rep_d;
      drop_q     <= drop_d;
    end
  end

endmodule

// File: tb/tb_rand_extractor.sv
// Self-checking bench for rand_extractor: directed scenarios plus randomized
// traffic compared cycle by cycle against a queue-based reference model.
module tb_rand_extractor;

  localparam int unsigned WORD_W     = 8;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned REP_LIMIT  = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] r;

  rand_extractor_if #(.WORD_W(WORD_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

  rand_extractor #(
    .WORD_W     (WORD_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .REP_LIMIT  (REP_LIMIT)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .i_en    (en),
    .i_r     (r),
    .out_if  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: list of buffered words and a list of pending bits.
  logic [7:0] m_q[$];
  int         m_bits[$];
  logic [1:0] m_prev;
  bit         m_prev_vld;
  int         m_rep;
  bit         m_fault;
  bit         m_drop;

  logic [7:0] rec[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_bits.delete();
    m_prev     = 2'b00;
    m_prev_vld = 0;
    m_rep      = 0;
    m_fault    = 0;
    m_drop     = 0;
  endtask

  // One clock edge of the model, given the inputs seen at that edge.
  task automatic model_edge(input logic e, input logic [1:0] sym, input logic rdy);
    logic [7:0] w;
    m_drop = 0;
    if (!m_fault && m_q.size() > 0 && rdy) void'(m_q.pop_front());
    if (e && !m_fault) begin
      m_rep      = (m_prev_vld && sym == m_prev) ? m_rep + 1 : 1;
      m_prev     = sym;
      m_prev_vld = 1;
      if (m_rep >= REP_LIMIT) begin
        m_fault = 1;
        m_q.delete();
        m_bits.delete();
      end else if (sym == 2'b01 || sym == 2'b10) begin
        m_bits.push_back(sym == 2'b10 ? 1 : 0);
        if (m_bits.size() == WORD_W) begin
          w = '0;
          foreach (m_bits[i]) w[WORD_W-1-i] = m_bits[i][0];
          m_bits.delete();
          if (m_q.size() < FIFO_DEPTH) m_q.push_back(w);
          else m_drop = 1;
        end
      end
    end
  endtask

  task automatic compare_model();
    bit exp_valid;
    exp_valid = !m_fault && (m_q.size() > 0);
    check("valid", 32'(bus.o_valid), 32'(exp_valid));
    check("count", 32'(bus.o_count), 32'(m_fault ? 0 : m_q.size()));
    check("fault", 32'(bus.o_fault), 32'(m_fault));
    check("drop",  32'(bus.o_drop),  32'(m_drop));
    if (exp_valid) check("data", 32'(bus.o_data), 32'(m_q[0]));
  endtask

  task automatic step(input logic e, input logic [1:0] sym, input logic rdy);
    @(negedge clk);
    en          = e;
    r           = sym;
    bus.i_ready = rdy;
    if (bus.o_valid && rdy) rec.push_back(bus.o_data);
    @(posedge clk);
    model_edge(e, sym, rdy);
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst         = 1'b1;
    en          = 1'b0;
    bus.i_ready = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    check("rst_valid", 32'(bus.o_valid), 32'd0);
    check("rst_count", 32'(bus.o_count), 32'd0);
    check("rst_drop",  32'(bus.o_drop),  32'd0);
    check("rst_fault", 32'(bus.o_fault), 32'd0);
    check("rst_data",  32'(bus.o_data),  32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic feed_word(input logic [7:0] w, input logic rdy, input logic rdy_last);
    for (int b = 7; b >= 0; b--) step(1'b1, w[b] ? 2'b10 : 2'b01, (b == 0) ? rdy_last : rdy);
  endtask

  task automatic check_rec(input string tag, input logic [7:0] exp[$]);
    check({tag, "_n"}, 32'(rec.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      check(tag, (i < rec.size()) ? 32'(rec[i]) : 32'hFFFF_FFFF, 32'(exp[i]));
  endtask

  initial begin
    logic [1:0] last_r;
    logic [1:0] sym;
    logic [7:0] exp_words[$];

    rst         = 1'b1;
    en          = 1'b0;
    r           = 2'b00;
    bus.i_ready = 1'b0;
    model_reset();
    do_reset();

    // 1: basic packing
    feed_word(8'hAA, 1'b1, 1'b1);
    check("s1_data",  32'(bus.o_data),  32'hAA);
    check("s1_valid", 32'(bus.o_valid), 32'd1);
    check("s1_count", 32'(bus.o_count), 32'd1);
    step(1'b0, 2'b00, 1'b1);
    check("s1_count_after", 32'(bus.o_count), 32'd0);

    // 2: discarded symbols interleaved
    for (int b = 7; b >= 0; b--) begin
      step(1'b1, 2'b00, 1'b1);
      step(1'b1, 2'b11, 1'b1);
      sym = (b % 2 == 1) ? 2'b10 : 2'b01;
      step(1'b1, sym, 1'b1);
    end
    check("s2_data",  32'(bus.o_data),  32'hAA);
    check("s2_count", 32'(bus.o_count), 32'd1);
    step(1'b0, 2'b00, 1'b1);
    step(1'b0, 2'b00, 1'b1);
    check("s2_no_extra", 32'(bus.o_valid), 32'd0);

    // 3: overflow and drain
    do_reset();
    feed_word(8'hAA, 1'b0, 1'b0);
    feed_word(8'h55, 1'b0, 1'b0);
    feed_word(8'hAA, 1'b0, 1'b0);
    feed_word(8'h55, 1'b0, 1'b0);
    check("s3_full", 32'(bus.o_count), 32'd4);
    feed_word(8'hF0, 1'b0, 1'b0);
    check("s3_drop",  32'(bus.o_drop),  32'd1);
    check("s3_count", 32'(bus.o_count), 32'd4);
    step(1'b0, 2'b00, 1'b0);
    check("s3_drop_once", 32'(bus.o_drop), 32'd0);
    rec.delete();
    for (int i = 0; i < 6; i++) step(1'b0, 2'b00, 1'b1);
    exp_words = '{8'hAA, 8'h55, 8'hAA, 8'h55};
    check_rec("s3_drain", exp_words);

    // 4: full FIFO with simultaneous pop on word completion
    do_reset();
    feed_word(8'hAA, 1'b0, 1'b0);
    feed_word(8'h55, 1'b0, 1'b0);
    feed_word(8'hAA, 1'b0, 1'b0);
    feed_word(8'h55, 1'b0, 1'b0);
    rec.delete();
    feed_word(8'h0F, 1'b0, 1'b1);
    check("s4_no_drop", 32'(bus.o_drop),  32'd0);
    check("s4_count",   32'(bus.o_count), 32'd4);
    for (int i = 0; i < 6; i++) step(1'b0, 2'b00, 1'b1);
    exp_words = '{8'hAA, 8'h55, 8'hAA, 8'h55, 8'h0F};
    check_rec("s4_drain", exp_words);

    // 5: fault trip, flush and recovery
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 2'b01, 1'b0);
      if (i == 8) begin
        check("s5_word",  32'(bus.o_data),  32'h00);
        check("s5_cnt8",  32'(bus.o_count), 32'd1);
      end
    end
    check("s5_fault", 32'(bus.o_fault), 32'd1);
    check("s5_valid", 32'(bus.o_valid), 32'd0);
    check("s5_count", 32'(bus.o_count), 32'd0);
    feed_word(8'hAA, 1'b0, 1'b0);
    check("s5_ignored", 32'(bus.o_count), 32'd0);
    check("s5_sticky",  32'(bus.o_fault), 32'd1);
    do_reset();
    feed_word(8'hAA, 1'b0, 1'b0);
    check("s5_resume", 32'(bus.o_data), 32'hAA);

    // 6: reset mid-word
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 2'b10, 1'b0);
    do_reset();
    feed_word(8'hAA, 1'b0, 1'b0);
    check("s6_data",  32'(bus.o_data),  32'hAA);
    check("s6_count", 32'(bus.o_count), 32'd1);

    // Randomized traffic; second half repeats symbols often to reach faults.
    do_reset();
    last_r = 2'b00;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        if (i >= 2000 && $urandom_range(0, 7) != 0) sym = last_r;
        else sym = 2'($urandom_range(0, 3));
        step($urandom_range(0, 9) != 0, sym, 1'($urandom_range(0, 1)));
        last_r = sym;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
